// File: rtl/uart_tx_byte.sv
// uart_tx_byte
//   Serial transmit stage: takes 1-cycle byte strobes and sends each byte as an
//   8N1 UART frame (LSB first). A one-entry holding register absorbs a byte
//   that arrives while a frame is on the line; the line idles high.
//
//   Optional feature macro: UART_TX_PARITY_EN
//     defined   -> one even-parity bit is inserted after the data bits (8E1, 11 bits)
//     undefined -> plain 8N1 (10 bits), no parity logic built
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_flag   in   1-cycle strobe, in_data valid
//   in_data   in   [7:0] byte to transmit
//   tx        out  serial line (registered), idle high
//   busy      out  high while a frame (start..stop) is on the line
//   tx_done   out  1-cycle pulse on the last clock of each stop bit
//   overflow  out  1-cycle pulse when an incoming byte is dropped
module uart_tx_byte #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_flag,
  input  logic [7:0] in_data,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic       overflow
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

`ifdef UART_TX_PARITY_EN
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             tx_d, busy_d, done_d, ovf_d;
  logic             last_bit, frame_end;

  // Control state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      hold_vld_q <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      tx_done    <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_vld_q <= hold_vld_d;
      tx         <= tx_d;
      busy       <= busy_d;
      tx_done    <= done_d;
      overflow   <= ovf_d;
    end
  end

  // Data registers carry no reset; their contents only matter once the
  // matching control bit (state / hold_vld) says they are valid.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    hold_q  <= hold_d;
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    ovf_d      = 1'b0;

    last_bit  = (baud_cnt_q == CNT_LAST);
    frame_end = (state_q == S_STOP) && last_bit;

    if (state_q != S_IDLE) begin
      baud_cnt_d = last_bit ? '0 : baud_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (in_flag) begin
          shift_d    = in_data;
          state_d    = S_START;
          baud_cnt_d = '0;
        end
      end
      S_START: begin
        if (last_bit) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (last_bit) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (last_bit) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (last_bit) begin
          // Chain straight into the next frame if anything is waiting; a
          // strobe landing on this very cycle refills the hold just drained.
          if (hold_vld_q) begin
            shift_d = hold_q;
            state_d = S_START;
            if (in_flag) hold_d = in_data;
            else         hold_vld_d = 1'b0;
          end else if (in_flag) begin
            shift_d = in_data;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Byte arriving mid-frame: park it, or drop it if the hold is occupied.
    if (in_flag && (state_q != S_IDLE) && !frame_end) begin
      if (!hold_vld_q) begin
        hold_d     = in_data;
        hold_vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end

    // Outputs are decoded from the next state so they register alongside it.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bit_cnt_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = even_parity(shift_d);
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (baud_cnt_d == CNT_LAST);
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
module tb_uart_tx_byte;

  localparam int B = 50_000_000 / 115_200;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FR = NBITS * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_flag = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       tx, busy, tx_done, overflow;

  uart_tx_byte #(.CLK_FREQ(50_000_000), .BAUD_RATE(115_200)) dut (
    .clk(clk), .rst_n(rst_n), .in_flag(in_flag), .in_data(in_data),
    .tx(tx), .busy(busy), .tx_done(tx_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         s;
    logic [7:0] d;
  } frame_t;

  int         st_cyc[$];
  logic [7:0] st_dat[$];
  frame_t     frames[$];
  int         ovf_cyc[$];
  logic [3:0] obs[$];   // {tx, busy, tx_done, overflow} per cycle
  logic [3:0] expv[$];
  logic [7:0] dec[$];

  task automatic clear_strobes();
    st_cyc.delete();
    st_dat.delete();
  endtask

  task automatic add_strobe(input int c, input logic [7:0] d);
    st_cyc.push_back(c);
    st_dat.push_back(d);
  endtask

  function automatic frame_t mkf(input int s, input logic [7:0] d);
    frame_t f;
    f.s = s;
    f.d = d;
    return f;
  endfunction

  // Reference model: schedule frames from strobe times using the line-occupancy
  // rules (free line, one-deep hold, drop when full), then paint the waveform.
  task automatic build_model(output int n, input int min_len);
    int cur_end;
    bit hv;
    logic [7:0] hd;
    frames.delete();
    ovf_cyc.delete();
    expv.delete();
    cur_end = -1;
    hv = 1'b0;
    hd = 8'h00;
    foreach (st_cyc[i]) begin
      int c;
      c = st_cyc[i];
      while (hv && cur_end < c) begin
        frames.push_back(mkf(cur_end + 1, hd));
        cur_end += FR;
        hv = 1'b0;
      end
      if (c > cur_end) begin
        frames.push_back(mkf(c + 1, st_dat[i]));
        cur_end = c + FR;
      end else if (c == cur_end) begin
        if (hv) begin
          frames.push_back(mkf(c + 1, hd));
          hd = st_dat[i];
        end else begin
          frames.push_back(mkf(c + 1, st_dat[i]));
        end
        cur_end = c + FR;
      end else if (!hv) begin
        hv = 1'b1;
        hd = st_dat[i];
      end else begin
        ovf_cyc.push_back(c + 1);
      end
    end
    if (hv) begin
      frames.push_back(mkf(cur_end + 1, hd));
      cur_end += FR;
    end
    n = (cur_end + 30 > min_len) ? cur_end + 30 : min_len;
    for (int k = 0; k < n; k++) begin
      logic [3:0] v;
      v = 4'b1000;
      foreach (frames[f]) begin
        if (k >= frames[f].s && k < frames[f].s + FR) begin
          int bi;
          bi = (k - frames[f].s) / B;
          if (bi == 0)                      v[3] = 1'b0;
          else if (bi <= 8)                 v[3] = frames[f].d[bi-1];
          else if (NBITS == 11 && bi == 9)  v[3] = ^frames[f].d;
          else                              v[3] = 1'b1;
          v[2] = 1'b1;
          v[1] = (k == frames[f].s + FR - 1);
        end
      end
      foreach (ovf_cyc[o]) if (ovf_cyc[o] == k) v[0] = 1'b1;
      expv.push_back(v);
    end
  endtask

  // Starts just after a rising edge; cycle k's inputs are applied, outputs
  // sampled on the falling edge, then the next rising edge is crossed.
  task automatic run_window(input int n);
    obs.delete();
    for (int k = 0; k < n; k++) begin
      in_flag = 1'b0;
      in_data = 8'($urandom);
      foreach (st_cyc[i]) begin
        if (st_cyc[i] == k) begin
          in_flag = 1'b1;
          in_data = st_dat[i];
        end
      end
      @(negedge clk);
      obs.push_back({tx, busy, tx_done, overflow});
      @(posedge clk);
      #1;
    end
    in_flag = 1'b0;
  endtask

  // Independent UART receiver: find start bits and sample mid-bit.
  task automatic decode();
    int i;
    dec.delete();
    i = 0;
    while (i < obs.size()) begin
      if (obs[i][3] == 1'b0) begin
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = obs[i + B/2 + (j+1)*B][3];
        dec.push_back(b);
        i += FR;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx !== 1'b1)       begin n_err++; $display("FAIL reset_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0)     begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (tx_done !== 1'b0)  begin n_err++; $display("FAIL reset_done got %b want 0", tx_done); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_strobes();
    build_model(n, 2000);
    run_window(n);
    for (int k = 0; k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++; $display("FAIL idle_wave cyc %0d got %b want %b", k, obs[k], expv[k]); break;
      end
    end
  endtask

  task automatic test_single_frame();
    int n, done_at, busy_cnt;
    int want_bits[8] = '{0, 1, 0, 1, 1, 0, 1, 0};
    clear_strobes();
    add_strobe(0, 8'h5A);
    build_model(n, 0);
    run_window(n);
    for (int k = 0; k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++; $display("FAIL frame5a_wave cyc %0d got %b want %b", k, obs[k], expv[k]); break;
      end
    end
    done_at = -1;
    busy_cnt = 0;
    foreach (obs[k]) begin
      if (obs[k][1] && done_at < 0) done_at = k;
      if (obs[k][2]) busy_cnt++;
    end
    n_cmp++; if (done_at != FR)   begin n_err++; $display("FAIL frame5a_done_at got %0d want %0d", done_at, FR); end
    n_cmp++; if (busy_cnt != FR)  begin n_err++; $display("FAIL frame5a_busy_len got %0d want %0d", busy_cnt, FR); end
    for (int j = 0; j < 8; j++) begin
      n_cmp++;
      if (int'(obs[1 + (j+1)*B + B/2][3]) != want_bits[j]) begin
        n_err++; $display("FAIL frame5a_bit%0d got %b want %0d", j, obs[1 + (j+1)*B + B/2][3], want_bits[j]);
      end
    end
`ifdef UART_TX_PARITY_EN
    n_cmp++;
    if (obs[1 + 9*B + B/2][3] !== 1'b0) begin
      n_err++; $display("FAIL frame5a_parity got %b want 0", obs[1 + 9*B + B/2][3]);
    end
`endif
  endtask

  task automatic test_string_pacing();
    int n, first_end, second_start, ovf_seen;
    logic [7:0] sent[4];
    sent[0] = 8'h5A;
    sent[1] = 8'h67;
    sent[2] = 8'($urandom);
    sent[3] = 8'($urandom);
    clear_strobes();
    for (int i = 0; i < 4; i++) add_strobe(i * (FR + 160), sent[i]);
    build_model(n, 0);
    run_window(n);
    for (int k = 0; k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++; $display("FAIL pacing_wave cyc %0d got %b want %b", k, obs[k], expv[k]); break;
      end
    end
    decode();
    n_cmp++;
    if (dec.size() != 4) begin
      n_err++; $display("FAIL pacing_count got %0d want 4", dec.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (dec[i] !== sent[i]) begin n_err++; $display("FAIL pacing_byte%0d got %h want %h", i, dec[i], sent[i]); end
      end
    end
    first_end = -1;
    second_start = -1;
    ovf_seen = 0;
    foreach (obs[k]) begin
      if (obs[k][0]) ovf_seen++;
      if (k > 0 && obs[k-1][2] && !obs[k][2] && first_end < 0) first_end = k;
      if (first_end >= 0 && second_start < 0 && obs[k][2]) second_start = k;
    end
    n_cmp++; if (second_start - first_end != 160) begin n_err++; $display("FAIL pacing_gap got %0d want 160", second_start - first_end); end
    n_cmp++; if (ovf_seen != 0) begin n_err++; $display("FAIL pacing_ovf got %0d want 0", ovf_seen); end
  endtask

  task automatic test_back_to_back();
    int n, dones;
    logic [7:0] third;
    third = 8'($urandom);
    clear_strobes();
    add_strobe(0, 8'h5A);
    add_strobe(100, 8'h3A);
    add_strobe(200, third);
    build_model(n, 0);
    run_window(n);
    for (int k = 0; k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++; $display("FAIL b2b_wave cyc %0d got %b want %b", k, obs[k], expv[k]); break;
      end
    end
    n_cmp++; if (obs[201][0] !== 1'b1) begin n_err++; $display("FAIL b2b_ovf_pulse got %b want 1", obs[201][0]); end
    n_cmp++; if (obs[FR+1][3:2] !== 2'b01) begin n_err++; $display("FAIL b2b_no_gap got %b want 01", obs[FR+1][3:2]); end
    dones = 0;
    foreach (obs[k]) if (obs[k][1]) dones++;
    n_cmp++; if (dones != 2) begin n_err++; $display("FAIL b2b_done_count got %0d want 2", dones); end
    decode();
    n_cmp++;
    if (dec.size() != 2) begin
      n_err++; $display("FAIL b2b_count got %0d want 2", dec.size());
    end else begin
      n_cmp++; if (dec[1] !== 8'h3A) begin n_err++; $display("FAIL b2b_second got %h want 3a", dec[1]); end
    end
  endtask

  task automatic test_coincident();
    int n;
    logic [7:0] r[3];
    for (int i = 0; i < 3; i++) r[i] = 8'($urandom);
    // Strobe on the last stop cycle with the hold empty.
    clear_strobes();
    add_strobe(0, r[0]);
    add_strobe(FR, r[1]);
    build_model(n, 0);
    run_window(n);
    for (int k = 0; k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++; $display("FAIL coinc_wave cyc %0d got %b want %b", k, obs[k], expv[k]); break;
      end
    end
    n_cmp++; if (obs[FR+1][3] !== 1'b0) begin n_err++; $display("FAIL coinc_start got %b want 0", obs[FR+1][3]); end
    // Same, but the hold is full: hold drains, the new byte refills it.
    clear_strobes();
    add_strobe(0, r[0]);
    add_strobe(50, r[1]);
    add_strobe(FR, r[2]);
    build_model(n, 0);
    run_window(n);
    for (int k = 0; k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++; $display("FAIL coinc_hold_wave cyc %0d got %b want %b", k, obs[k], expv[k]); break;
      end
    end
    decode();
    n_cmp++;
    if (dec.size() != 3) begin
      n_err++; $display("FAIL coinc_hold_count got %0d want 3", dec.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (dec[i] !== r[i]) begin n_err++; $display("FAIL coinc_hold_byte%0d got %h want %h", i, dec[i], r[i]); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int n;
    clear_strobes();
    add_strobe(0, 8'hA5);
    build_model(n, 0);
    run_window(1 + 4*B + B/2);
    for (int k = 0; k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++; $display("FAIL midrst_pre cyc %0d got %b want %b", k, obs[k], expv[k]); break;
      end
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (tx !== 1'b1)   begin n_err++; $display("FAIL midrst_tx got %b want 1", tx); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (tx_done !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", tx_done); end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_strobes();
    add_strobe(0, 8'h79);
    build_model(n, 0);
    run_window(n);
    for (int k = 0; k < obs.size(); k++) begin
      n_cmp++;
      if (obs[k] !== expv[k]) begin
        n_err++; $display("FAIL midrst_79_wave cyc %0d got %b want %b", k, obs[k], expv[k]); break;
      end
    end
    decode();
    n_cmp++;
    if (dec.size() != 1 || dec[0] !== 8'h79) begin
      n_err++; $display("FAIL midrst_79_byte got %0d bytes first %h want 1 byte 79", dec.size(), (dec.size() > 0) ? dec[0] : 8'h00);
    end
`ifdef UART_TX_PARITY_EN
    n_cmp++;
    if (obs[1 + 9*B + B/2][3] !== 1'b1) begin
      n_err++; $display("FAIL midrst_79_parity got %b want 1", obs[1 + 9*B + B/2][3]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_string_pacing();
    test_back_to_back();
    test_coincident();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
